rv_alu_issue: RTL and testbench
===============================

# rv_alu_issue

Decode-and-issue stage that sits upstream of the RV32I ALU. It accepts one instruction per cycle with its PC and register-file read data over a valid/ready handshake. It decodes the instruction into the 4-bit ALU operation select and muxes the two operands (rs1/PC/zero and rs2/immediate/4). It presents the result to the ALU-side consumer through a registered valid/ready output stage.

## Interface
- No parameters; all widths fixed (XLEN = 32).
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- instr_vld_i  input  1  upstream instruction valid
- instr_rdy_o  output  1  stage can accept an instruction this cycle
- instr_i  input  32  RV32I instruction word
- pc_i  input  32  PC of instr_i
- rs1_data_i  input  32  register file read data for rs1
- rs2_data_i  input  32  register file read data for rs2
- alu_vld_o  output  1  issued operation valid
- alu_rdy_i  input  1  downstream accepts issued operation
- opr_a_o  output  32  ALU operand A
- opr_b_o  output  32  ALU operand B
- op_sel_o  output  4  ALU op: ADD=0, SUB=1, SLL=2, LSR=3, ASR=4, OR=5, AND=6, XOR=7, EQL=8, ULT=9, UGE=A, SLT=B, SGE=C
- rd_o  output  5  destination register, instr_i[11:7]
- illegal_o  output  1  issued entry came from an undecodable instruction

## Operation
- An input transfer occurs when instr_vld_i && instr_rdy_o. An output transfer occurs when alu_vld_o && alu_rdy_i.
- Immediates are sign-extended to 32 bits. Types: I, S, U (imm[31:12] followed by 12 zero bits).
- OP (0110011): A=rs1, B=rs2.
  - funct3 000: ADD if funct7=0x00, SUB if funct7=0x20.
  - funct3 001: SLL. 010: SLT. 011: ULT. 100: XOR.
  - funct3 101: LSR if funct7=0x00, ASR if funct7=0x20.
  - funct3 110: OR. 111: AND.
  - Any other funct7 is illegal.
- OP-IMM (0010011): A=rs1, B=I-imm; same funct3 map as OP, with no SUB.
  - Shifts require funct7 0x00 (SLLI/SRLI) or 0x20 (SRAI only); otherwise illegal.
  - For shifts, B=shamt zero-extended.
- LUI (0110111): A=0, B=U-imm, ADD.
- AUIPC (0010111): A=pc, B=U-imm, ADD.
- LOAD (0000011): A=rs1, B=I-imm, ADD.
- STORE (0100011): A=rs1, B=S-imm, ADD.
- BRANCH (1100011): A=rs1, B=rs2.
  - 000/001: EQL (the branch unit inverts for BNE).
  - 100: SLT. 101: SGE. 110: ULT. 111: UGE.
  - 010/011: illegal.
- JAL (1101111), JALR (1100111, funct3=000 only): A=pc, B=32'd4, ADD (link value).
- Anything else: illegal_o=1, op_sel=ADD, A=B=0, rd_o still forwarded. Illegal entries obey the same handshake as legal ones.
- Held output: while alu_vld_o && !alu_rdy_i, all output fields remain stable.

## Timing
- Latency: an accepted instruction appears on the outputs on the next rising edge.
- Throughput: 1 op/cycle when alu_rdy_i is held high.
- Reset values:
  - alu_vld_o=0; opr_a_o, opr_b_o, op_sel_o, rd_o, illegal_o all =0.
  - Internal skid entry empty; instr_rdy_o=1 after reset.
- Reset asserted mid-operation: every buffered entry is discarded immediately (asynchronous); nothing is reissued.
- Simultaneous input and output transfer in the same cycle: the output register is refilled with no bubble.
- Empty output stage (alu_vld_o=0): accepts regardless of alu_rdy_i.

## Configuration
- RV_ALU_ISSUE_SKID_EN defined:
  - A 2-entry skid buffer is built: the output register plus one skid register.
  - instr_rdy_o is driven directly from a flop: instr_rdy_o = !skid_full.
  - A transfer arriving while the output is stalled goes to the skid register. The skid entry moves to the output on the next output transfer.
  - Ordering is preserved.
- RV_ALU_ISSUE_SKID_EN undefined:
  - A single output register only.
  - instr_rdy_o = !alu_vld_o || alu_rdy_i (combinational from alu_rdy_i).
  - Latency and throughput are identical; no instruction is ever lost.

## Test plan
- ADDI x5,x1,-3 (0xFFD08293), rs1=10, alu_rdy_i=1 -> next cycle: alu_vld_o=1, op_sel=0, A=10, B=0xFFFFFFFD, rd_o=5, illegal_o=0.
- SRAI x2,x3,7 (0x4071D113) then SUB x1,x2,x3 (0x403100B3), back-to-back -> two consecutive cycles: op_sel=4 with B=7, then op_sel=1 with B=rs2.
- BGEU, AUIPC at pc=0x1000 with imm 0x12345, and JAL at pc=0x80 -> op_sel=A with A/B=rs1/rs2; ADD with A=0x1000, B=0x12345000; ADD with A=0x80, B=4.
- Illegal word 0x0000007F -> illegal_o=1, op_sel=0, A=B=0, handshake completes normally.
- Stream of 4 instructions with alu_rdy_i low for 3 cycles:
  - SKID_EN: instr_rdy_o drops 1 cycle after the second accept; outputs stay stable while stalled; all 4 are issued in order.
  - Without SKID_EN: instr_rdy_o follows alu_rdy_i in the same cycle.
- reset_n pulsed low while alu_vld_o=1 and the skid is full -> alu_vld_o=0 immediately; after release, instr_rdy_o=1 and no stale entry is issued.

Source files
------------

// File: rtl/rv_alu_issue_if.sv
// rv_alu_issue_if: issue-stage handshake bundle.
// Upstream instr side (vld/rdy + instr, pc, rs data) and ALU side (vld/rdy + operands).
// Ports (slave = issue stage):
//   instr_vld_i/instr_rdy_o, instr_i, pc_i, rs1_data_i, rs2_data_i
//   alu_vld_o/alu_rdy_i, opr_a_o, opr_b_o, op_sel_o, rd_o, illegal_o
interface rv_alu_issue_if;
  logic        instr_vld_i;
  logic        instr_rdy_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        alu_vld_o;
  logic        alu_rdy_i;
  logic [31:0] opr_a_o;
  logic [31:0] opr_b_o;
  logic [3:0]  op_sel_o;
  logic [4:0]  rd_o;
  logic        illegal_o;

  modport slave (
    input  instr_vld_i, instr_i, pc_i,
    input  rs1_data_i, rs2_data_i, alu_rdy_i,
    output instr_rdy_o, alu_vld_o,
    output opr_a_o, opr_b_o, op_sel_o,
    output rd_o, illegal_o
  );

  modport master (
    output instr_vld_i, instr_i, pc_i,
    output rs1_data_i, rs2_data_i, alu_rdy_i,
    input  instr_rdy_o, alu_vld_o,
    input  opr_a_o, opr_b_o, op_sel_o,
    input  rd_o, illegal_o
  );
endinterface

// File: rtl/rv_alu_issue.sv
// rv_alu_issue: RV32I decode-and-issue stage feeding the ALU.
// Decodes op select, muxes operands, registers result behind valid/ready.
// Ports: clk, reset_n (async active-low), bus (rv_alu_issue_if.slave).
// Option: RV_ALU_ISSUE_SKID_EN adds a skid entry so instr_rdy_o is a flop.
module rv_alu_issue (
  input  logic          clk,
  input  logic          reset_n,
  rv_alu_issue_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SLL = 4'h2;
  localparam logic [3:0] OP_LSR = 4'h3;
  localparam logic [3:0] OP_ASR = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_EQL = 4'h8;
  localparam logic [3:0] OP_ULT = 4'h9;
  localparam logic [3:0] OP_UGE = 4'hA;
  localparam logic [3:0] OP_SLT = 4'hB;
  localparam logic [3:0] OP_SGE = 4'hC;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } ent_t;

  // alt selects SUB/ASR on the funct7=0x20 encodings
  function automatic logic [3:0] f3_op(
    input logic [2:0] f3,
    input logic       alt
  );
    unique case (f3)
      3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_ULT;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = alt ? OP_ASR : OP_LSR;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  endfunction

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic        f7_0;
  logic        f7_20;
  logic        shf;
  ent_t        dec;

  assign ins   = bus.instr_i;
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign f7_0  = (f7 == 7'h00);
  assign f7_20 = (f7 == 7'h20);
  assign shf   = (f3 == 3'b001) || (f3 == 3'b101);
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_u = {ins[31:12], 12'h000};

  always_comb begin
    dec.a   = 32'h0;
    dec.b   = 32'h0;
    dec.op  = OP_ADD;
    dec.rd  = ins[11:7];
    dec.ill = 1'b0;
    unique case (1'b1)
      opc == 7'b0110011: begin
        dec.a   = bus.rs1_data_i;
        dec.b   = bus.rs2_data_i;
        dec.op  = f3_op(f3, f7_20);
        dec.ill = !(f7_0 ||
                    (f7_20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      opc == 7'b0010011: begin
        dec.a   = bus.rs1_data_i;
        dec.b   = shf ? {27'h0, ins[24:20]} : imm_i;
        dec.op  = f3_op(f3, f3 == 3'b101 && f7_20);
        dec.ill = shf && !(f7_0 || (f3 == 3'b101 && f7_20));
      end
      opc == 7'b0110111: begin
        dec.b = imm_u;
      end
      opc == 7'b0010111: begin
        dec.a = bus.pc_i;
        dec.b = imm_u;
      end
      opc == 7'b0000011: begin
        dec.a = bus.rs1_data_i;
        dec.b = imm_i;
      end
      opc == 7'b0100011: begin
        dec.a = bus.rs1_data_i;
        dec.b = imm_s;
      end
      opc == 7'b1100011: begin
        dec.a = bus.rs1_data_i;
        dec.b = bus.rs2_data_i;
        unique case (f3)
          3'b000, 3'b001: dec.op = OP_EQL;
          3'b100:         dec.op = OP_SLT;
          3'b101:         dec.op = OP_SGE;
          3'b110:         dec.op = OP_ULT;
          3'b111:         dec.op = OP_UGE;
          default:        dec.ill = 1'b1;
        endcase
      end
      (opc == 7'b1101111) ||
      (opc == 7'b1100111 && f3 == 3'b000): begin
        dec.a = bus.pc_i;
        dec.b = 32'd4;
      end
      default: dec.ill = 1'b1;
    endcase
    // illegal entries carry a clean ADD 0,0 so the ALU result is benign
    if (dec.ill) begin
      dec.a  = 32'h0;
      dec.b  = 32'h0;
      dec.op = OP_ADD;
    end
  end

  ent_t out_q, out_d;
  logic vld_q, vld_d;
  logic rdy;
  logic in_xfer;
  logic out_xfer;

  assign out_xfer = vld_q && bus.alu_rdy_i;
  assign in_xfer  = bus.instr_vld_i && rdy;

`ifdef RV_ALU_ISSUE_SKID_EN
  ent_t skid_q, skid_d;
  logic skid_vld_q, skid_vld_d;

  assign rdy = !skid_vld_q;

  always_comb begin
    out_d      = out_q;
    vld_d      = vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!vld_q || out_xfer) begin
      // skid full implies rdy=0, so no input can race the refill
      if (skid_vld_q) begin
        out_d      = skid_q;
        vld_d      = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        out_d = dec;
        vld_d = 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign rdy = !vld_q || bus.alu_rdy_i;

  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    if (in_xfer) begin
      out_d = dec;
      vld_d = 1'b1;
    end else if (out_xfer) begin
      vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign bus.instr_rdy_o = rdy;
  assign bus.alu_vld_o   = vld_q;
  assign bus.opr_a_o     = out_q.a;
  assign bus.opr_b_o     = out_q.b;
  assign bus.op_sel_o    = out_q.op;
  assign bus.rd_o        = out_q.rd;
  assign bus.illegal_o   = out_q.ill;

endmodule

// File: tb/tb_rv_alu_issue.sv
// tb_rv_alu_issue: directed vector bench for rv_alu_issue.
// Decode table, stall/stream ordering and async reset flush.
module tb_rv_alu_issue;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  rv_alu_issue_if bus();

  rv_alu_issue dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  localparam int NV = 21;
  vec_t v [NV];

  int total = 0;
  int bad = 0;

  function automatic logic [74:0] obs();
    return {bus.alu_vld_o, bus.opr_a_o, bus.opr_b_o,
            bus.op_sel_o, bus.rd_o, bus.illegal_o};
  endfunction

  function automatic logic [74:0] exp_of(input vec_t x);
    return {1'b1, x.a, x.b, x.op, x.rd, x.ill};
  endfunction

  task automatic chk(input string nm,
                     input logic [74:0] act,
                     input logic [74:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x, input logic vld);
    bus.instr_vld_i = vld;
    bus.instr_i     = x.instr;
    bus.pc_i        = x.pc;
    bus.rs1_data_i  = x.rs1;
    bus.rs2_data_i  = x.rs2;
  endtask

  initial begin
    int sent;
    int got;
    int a2;
    logic stall_prev;
    logic [74:0] prev;

    v[0]  = '{32'hFFD08293, 0, 10, 0,
              10, 32'hFFFFFFFD, 4'h0, 5, 0};
    v[1]  = '{32'h4071D113, 0, 32'h80000000, 0,
              32'h80000000, 7, 4'h4, 2, 0};
    v[2]  = '{32'h403100B3, 0, 100, 30,
              100, 30, 4'h1, 1, 0};
    v[3]  = '{32'h0020F463, 0, 5, 6,
              5, 6, 4'hA, 8, 0};
    v[4]  = '{32'h12345397, 32'h1000, 32'h55, 32'h66,
              32'h1000, 32'h12345000, 4'h0, 7, 0};
    v[5]  = '{32'h000000EF, 32'h80, 1, 2,
              32'h80, 4, 4'h0, 1, 0};
    v[6]  = '{32'h0000007F, 32'h40, 32'h11, 32'h22,
              0, 0, 4'h0, 0, 1};
    v[7]  = '{32'hABCDE1B7, 0, 32'h99, 0,
              0, 32'hABCDE000, 4'h0, 3, 0};
    v[8]  = '{32'hFE20AE23, 0, 32'h200, 7,
              32'h200, 32'hFFFFFFFC, 4'h0, 28, 0};
    v[9]  = '{32'h0100A203, 0, 32'h300, 0,
              32'h300, 16, 4'h0, 4, 0};
    v[10] = '{32'h023100B3, 0, 1, 2,
              0, 0, 4'h0, 1, 1};
    v[11] = '{32'h40311093, 0, 1, 2,
              0, 0, 4'h0, 1, 1};
    v[12] = '{32'h0020C063, 0, 7, 8,
              7, 8, 4'hB, 0, 0};
    v[13] = '{32'h0020A063, 0, 7, 8,
              0, 0, 4'h0, 0, 1};
    v[14] = '{32'h000100E7, 32'h444, 9, 0,
              32'h444, 4, 4'h0, 1, 0};
    v[15] = '{32'h000110E7, 32'h444, 9, 0,
              0, 0, 4'h0, 1, 1};
    v[16] = '{32'hFFF0B313, 0, 3, 0,
              3, 32'hFFFFFFFF, 4'h9, 6, 0};
    v[17] = '{32'h007372B3, 0, 32'hF0, 32'h3C,
              32'hF0, 32'h3C, 4'h6, 5, 0};
    v[18] = '{32'h003150B3, 0, 8, 2,
              8, 2, 4'h3, 1, 0};
    v[19] = '{32'h00209063, 0, 4, 4,
              4, 4, 4'h8, 0, 0};
    v[20] = '{32'h0FF14093, 0, 32'h12, 0,
              32'h12, 32'hFF, 4'h7, 1, 0};

    drive(v[0], 1'b0);
    bus.alu_rdy_i = 1'b0;

    // reset state; empty stage is ready even with alu_rdy_i low
    #12;
    chk("reset_outs", obs(), 75'h0);
    chk("reset_rdy", 75'(bus.instr_rdy_o), 75'h1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back decode table at full throughput
    bus.alu_rdy_i = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(v[i], 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), obs(), exp_of(v[i]));
    end
    drive(v[0], 1'b0);
    @(posedge clk);
    #1;
    chk("drain", 75'(bus.alu_vld_o), 75'h0);

    // 4-entry stream, alu_rdy_i low on cycles 1..3
    sent = 0;
    got = 0;
    a2 = -1;
    stall_prev = 1'b0;
    prev = '0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      bus.alu_rdy_i = !(c >= 1 && c <= 3);
      if (sent < 4) drive(v[sent], 1'b1);
      else drive(v[0], 1'b0);
      @(negedge clk);
      if (stall_prev) chk("hold", obs(), prev);
`ifdef RV_ALU_ISSUE_SKID_EN
      if (a2 >= 0 && c == a2 + 1)
        chk("skid_rdy_drop", 75'(bus.instr_rdy_o), 75'h0);
`else
      chk("rdy_follow", 75'(bus.instr_rdy_o),
          75'(!bus.alu_vld_o || bus.alu_rdy_i));
`endif
      if (bus.alu_vld_o && bus.alu_rdy_i) begin
        chk($sformatf("stream%0d", got), obs(), exp_of(v[got]));
        got++;
      end
      if (bus.instr_vld_i && bus.instr_rdy_o) begin
        sent++;
        if (sent == 2) a2 = c;
      end
      stall_prev = bus.alu_vld_o && !bus.alu_rdy_i;
      prev = obs();
      @(posedge clk);
      #1;
    end
    chk("stream_cnt", 75'(got), 75'd4);
    drive(v[0], 1'b0);
    @(posedge clk);
    #1;

    // fill the stage while stalled, then pulse reset mid-cycle
    bus.alu_rdy_i = 1'b0;
    drive(v[4], 1'b1);
    @(posedge clk);
    #1;
    drive(v[5], 1'b1);
    @(posedge clk);
    #1;
    drive(v[0], 1'b0);
    #2;
    chk("pre_rst_vld", 75'(bus.alu_vld_o), 75'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_async", obs(), 75'h0);
    chk("rst_rdy", 75'(bus.instr_rdy_o), 75'h1);
    @(negedge clk);
    reset_n = 1'b1;
    bus.alu_rdy_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("no_stale%0d", k),
          75'(bus.alu_vld_o), 75'h0);
    end
    chk("post_rst_rdy", 75'(bus.instr_rdy_o), 75'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
